// File: rtl/rr_mem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between CORE_NUM cores.
// One access in flight at a time; read latency is hidden behind a per-core response pulse.
module rr_mem_arbiter #(
  parameter int WIDTH       = 32,
  parameter int CORE_NUM    = 4,
  parameter int RAM_LATENCY = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CORE_NUM-1:0]       request,
  input  logic [CORE_NUM-1:0]       wren_core,
  input  logic [CORE_NUM*WIDTH-1:0] address_in,
  input  logic [CORE_NUM*WIDTH-1:0] data_in,
  output logic [CORE_NUM*WIDTH-1:0] data_out,
  output logic [CORE_NUM-1:0]       response,
  output logic [CORE_NUM-1:0]       grant,
  output logic                      busy,
  output logic [WIDTH-1:0]          address,
  output logic [WIDTH-1:0]          data_write,
  output logic                      wren,
  input  logic [WIDTH-1:0]          data_read
);

  // state  | meaning
  // IDLE   | no access; arbitrate among pending requests
  // ISSUE  | drive latched access to the RAM for one cycle
  // WAIT   | read in flight; count down RAM latency, capture q on last cycle
  // RESP   | pulse response for the owner
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  localparam int IDX_W = $clog2(CORE_NUM);
  localparam int CNT_W = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;

  state_t              state, state_nx;
  logic [IDX_W-1:0]    sel;
  logic [IDX_W-1:0]    last;
  logic                lat_wren;
  logic [CNT_W-1:0]    cnt;
  logic [CORE_NUM-1:0] sel_onehot;
  logic                found;
  logic [IDX_W-1:0]    pick_idx;

  assign sel_onehot = {{(CORE_NUM-1){1'b0}}, 1'b1} << sel;

  // Search starts one past the previous owner and wraps, giving the rotation.
  always_comb begin
    logic [IDX_W-1:0] cand;
    found    = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int k = 1; k <= CORE_NUM; k++) begin
      cand = IDX_W'((int'(last) + k) % CORE_NUM);
      if (!found && request[cand]) begin
        found    = 1'b1;
        pick_idx = cand;
      end
    end
  end

  always_comb begin
    state_nx = state;
    grant    = '0;
    response = '0;
    wren     = 1'b0;
    busy     = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (found) state_nx = S_ISSUE;
      end
      S_ISSUE: begin
        grant    = sel_onehot;
        wren     = lat_wren;
        state_nx = lat_wren ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        grant = sel_onehot;
        if (cnt == '0) state_nx = S_RESP;
      end
      S_RESP: begin
        grant    = sel_onehot;
        response = sel_onehot;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sel        <= '0;
      last       <= IDX_W'(CORE_NUM - 1);
      lat_wren   <= 1'b0;
      address    <= '0;
      data_write <= '0;
      cnt        <= '0;
      data_out   <= '0;
    end else begin
      if (state == S_IDLE && found) begin
        sel        <= pick_idx;
        last       <= pick_idx;
        lat_wren   <= wren_core[pick_idx];
        address    <= address_in[int'(pick_idx)*WIDTH +: WIDTH];
        data_write <= data_in[int'(pick_idx)*WIDTH +: WIDTH];
      end
      if (state == S_ISSUE)
        cnt <= CNT_W'(RAM_LATENCY - 1);
      else if (state == S_WAIT && cnt != '0)
        cnt <= cnt - CNT_W'(1);
      // q is valid on the final wait cycle; owner sees it from RESP onward.
      if (state == S_WAIT && cnt == '0)
        data_out[int'(sel)*WIDTH +: WIDTH] <= data_read;
    end
  end

endmodule

// File: tb/tb_rr_mem_arbiter.sv
// Directed bench for rr_mem_arbiter with a 2-cycle-latency RAM model.
module tb_rr_mem_arbiter;

  logic         clk;
  logic         reset;
  logic [3:0]   request;
  logic [3:0]   wren_core;
  logic [127:0] address_in;
  logic [127:0] data_in;
  logic [127:0] data_out;
  logic [3:0]   response;
  logic [3:0]   grant;
  logic         busy;
  logic [31:0]  address;
  logic [31:0]  data_write;
  logic         wren;
  logic [31:0]  data_read;

  int checks = 0;
  int errors = 0;

  rr_mem_arbiter #(.WIDTH(32), .CORE_NUM(4), .RAM_LATENCY(2)) dut (
    .clk(clk), .reset(reset), .request(request), .wren_core(wren_core),
    .address_in(address_in), .data_in(data_in), .data_out(data_out),
    .response(response), .grant(grant), .busy(busy), .address(address),
    .data_write(data_write), .wren(wren), .data_read(data_read)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [0:15];
  logic [31:0] q1, q2;
  always @(posedge clk) begin
    if (wren) mem[address[3:0]] <= data_write;
    q1 <= mem[address[3:0]];
    q2 <= q1;
  end
  assign data_read = q2;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_resp(input int max, output logic [3:0] resp, output int cyc);
    resp = '0;
    cyc  = 0;
    while (cyc < max) begin
      step();
      cyc++;
      if (response != '0) begin
        resp = response;
        break;
      end
    end
  endtask

  function automatic logic [31:0] dout(input int k);
    return data_out[k*32 +: 32];
  endfunction

  task automatic set_core(input int k, input logic wr, input logic [31:0] a, input logic [31:0] d);
    wren_core[k]         = wr;
    address_in[k*32 +: 32] = a;
    data_in[k*32 +: 32]    = d;
  endtask

  logic [3:0] resp;
  int         cyc;

  initial begin
    reset      = 1'b1;
    request    = '0;
    wren_core  = '0;
    address_in = '0;
    data_in    = '0;
    step();
    step();
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_resp", response, 0);
    chk("rst_wren", wren, 0);
    chk("rst_addr", address, 0);
    chk("rst_dout", data_out, 0);
    reset = 1'b0;
    step();

    // Test 1: core 0 writes 3*i to addr i
    for (int i = 0; i < 5; i++) begin
      set_core(0, 1'b1, i, 3*i);
      request = 4'b0001;
      step();
      chk("t1_wren", wren, 1);
      chk("t1_addr", address, i);
      chk("t1_wdata", data_write, 3*i);
      chk("t1_grant", grant, 4'b0001);
      step();
      chk("t1_resp", response, 4'b0001);
      chk("t1_wren_off", wren, 0);
      request = '0;
      step();
      chk("t1_idle", busy, 0);
    end
    for (int i = 0; i < 5; i++) chk("t1_mem", mem[i], 3*i);

    // Test 2: core 1 reads addr 3
    set_core(1, 1'b0, 3, 0);
    request = 4'b0010;
    step();
    chk("t2_addr", address, 3);
    chk("t2_grant", grant, 4'b0010);
    chk("t2_wren", wren, 0);
    step();
    chk("t2_noresp_a", response, 0);
    step();
    chk("t2_noresp_b", response, 0);
    step();
    chk("t2_resp", response, 4'b0010);
    chk("t2_dout1", dout(1), 9);
    chk("t2_dout0", dout(0), 0);
    request = '0;
    step();

    // Test 3: reset restores last=3, then all four read at once
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) set_core(k, 1'b0, 4 - k, 0);
    request = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      wait_resp(12, resp, cyc);
      chk("t3_resp", resp, 4'b0001 << k);
      chk("t3_grant", grant, 4'b0001 << k);
      chk("t3_cycles", cyc, (k == 0) ? 4 : 5);
      chk("t3_dout", dout(k), 3*(4 - k));
      request[k] = 1'b0;
    end
    step();
    chk("t3_idle", busy, 0);

    // Test 4: core 1 write sets last=1, then cores 2 and 0 both hold requests
    set_core(1, 1'b1, 8, 32'h55);
    request = 4'b0010;
    wait_resp(6, resp, cyc);
    chk("t4_pre", resp, 4'b0010);
    request = '0;
    step();
    set_core(0, 1'b1, 11, 32'hB);
    set_core(2, 1'b1, 10, 32'hA);
    request = 4'b0101;
    for (int n = 0; n < 4; n++) begin
      wait_resp(8, resp, cyc);
      chk("t4_alt", resp, (n % 2 == 0) ? 4'b0100 : 4'b0001);
    end
    request = '0;
    step();
    chk("t4_mem10", mem[10], 32'hA);
    chk("t4_mem11", mem[11], 32'hB);

    // Test 5: reset during WAIT of a read by core 1
    set_core(1, 1'b0, 3, 0);
    request = 4'b0010;
    step();
    chk("t5_grant", grant, 4'b0010);
    step();
    chk("t5_busy_wait", busy, 1);
    reset = 1'b1;
    step();
    chk("t5_grant_rst", grant, 0);
    chk("t5_busy_rst", busy, 0);
    chk("t5_resp_rst", response, 0);
    reset   = 1'b0;
    request = '0;
    for (int n = 0; n < 4; n++) begin
      step();
      chk("t5_noresp", response, 0);
    end
    set_core(0, 1'b0, 2, 0);
    set_core(1, 1'b0, 4, 0);
    request = 4'b0011;
    wait_resp(8, resp, cyc);
    chk("t5_winner", resp, 4'b0001);
    chk("t5_dout0", dout(0), 6);
    chk("t5_dout1_held", dout(1), 0);
    request[0] = 1'b0;
    wait_resp(8, resp, cyc);
    chk("t5_second", resp, 4'b0010);
    chk("t5_dout1", dout(1), 12);
    request = '0;
    step();

    // Test 6: core 3 writes addr 7 = 28, core 1 reads it back-to-back
    set_core(3, 1'b1, 7, 28);
    set_core(1, 1'b0, 7, 0);
    request = 4'b1010;
    wait_resp(6, resp, cyc);
    chk("t6_wr_resp", resp, 4'b1000);
    chk("t6_wr_cycles", cyc, 2);
    request[3] = 1'b0;
    wait_resp(10, resp, cyc);
    chk("t6_rd_resp", resp, 4'b0010);
    chk("t6_rd_cycles", cyc, 5);
    chk("t6_dout1", dout(1), 28);
    chk("t6_dout3", dout(3), 0);
    request = '0;
    step();
    chk("t6_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
